// File: rtl/const_gate_pipe_pkg.sv
// Shared types and the per-channel tie function for the constant-gated AND pipeline.
package const_gate_pkg;

  // Per-channel source of the b operand.
  typedef enum logic [1:0] {
    TIE_LIVE = 2'b00,
    TIE_GND  = 2'b01,
    TIE_VCC  = 2'b10,
    TIE_X    = 2'b11
  } tie_mode_e;

  // Mode-change controller states.
  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_DRAIN = 2'b01,
    ST_APPLY = 2'b10
  } fsm_state_e;

  // One channel of y = a & b with b optionally tied; X channels emit a fixed fill
  // value so simulation stays deterministic.
  function automatic logic tie_apply(input logic a, input logic b,
                                     input tie_mode_e mode, input logic x_fill);
    logic y;
    unique case (mode)
      TIE_LIVE: y = a & b;
      TIE_GND:  y = 1'b0;
      TIE_VCC:  y = a;
      default:  y = x_fill;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/const_gate_pipe_if.sv
// Data, result and configuration handshakes of const_gate_pipe bundled as one interface.
interface const_gate_pipe_if #(parameter int WIDTH = 4);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_y;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [2*WIDTH-1:0] cfg_mode;
  logic [2*WIDTH-1:0] mode_q;

  // Producer/consumer side (drives operands, accepts results, offers modes).
  modport master (
    output in_valid, in_a, in_b, out_ready, cfg_valid, cfg_mode,
    input  in_ready, out_valid, out_y, cfg_ready, mode_q
  );

  // Pipeline side.
  modport slave (
    input  in_valid, in_a, in_b, out_ready, cfg_valid, cfg_mode,
    output in_ready, out_valid, out_y, cfg_ready, mode_q
  );

endinterface

// File: rtl/const_gate_pipe_stage.sv
// One valid/ready register slice; holds its beat while the next slice is full and stalled.
module const_gate_stage
  import const_gate_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  assign in_ready  = ~valid_q | out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // Load a new beat (or go empty) whenever the slice is empty or its beat is leaving.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (in_ready) begin
      valid_q <= in_valid;
      if (in_valid) begin
        data_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/const_gate_pipe.sv
// WIDTH-channel y = a & b with per-channel tied b, a DEPTH-deep valid/ready pipeline,
// and a drain-before-apply controller so a mode never changes under in-flight beats.
module const_gate_pipe
  import const_gate_pkg::*;
#(
  parameter int               WIDTH      = 4,
  parameter int               DEPTH      = 2,
  parameter bit               X_FILL     = 1'b0,
  parameter logic [2*WIDTH-1:0] RESET_MODE = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  const_gate_pipe_if.slave bus
);

  fsm_state_e         state_q;
  fsm_state_e         state_d;
  logic [2*WIDTH-1:0] mode_reg;
  logic               run;
  logic               busy;
  logic [WIDTH-1:0]   gated;

  logic               v [0:DEPTH];
  logic               r [0:DEPTH];
  logic [WIDTH-1:0]   d [0:DEPTH];

  // Gate each channel with the mode in force when the beat is accepted; the
  // pipeline then only carries results, so later mode changes cannot touch it.
  always_comb begin
    gated = '0;
    for (int i = 0; i < WIDTH; i++) begin
      gated[i] = tie_apply(bus.in_a[i], bus.in_b[i],
                           tie_mode_e'(mode_reg[2*i +: 2]), X_FILL);
    end
  end

  assign v[0]         = bus.in_valid & run;
  assign d[0]         = gated;
  assign r[DEPTH]     = bus.out_ready;
  assign bus.in_ready = r[0] & run;
  assign bus.out_valid = v[DEPTH];
  assign bus.out_y    = d[DEPTH];
  assign bus.mode_q   = mode_reg;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    const_gate_stage #(.WIDTH(WIDTH)) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (v[k]),
      .in_ready  (r[k]),
      .in_data   (d[k]),
      .out_valid (v[k+1]),
      .out_ready (r[k+1]),
      .out_data  (d[k+1])
    );
  end

  // Pipe is drained only when every slice is empty.
  always_comb begin
    busy = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      busy = busy | v[k];
    end
  end

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Applied mode; only the APPLY state may change it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_reg <= RESET_MODE;
    end else if (state_q == ST_APPLY) begin
      mode_reg <= bus.cfg_mode;
    end
  end

  // Next state, input gating and the one-cycle cfg_ready pulse.
  always_comb begin
    state_d       = state_q;
    run           = 1'b0;
    bus.cfg_ready = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        run = 1'b1;
        if (bus.cfg_valid) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!bus.cfg_valid) begin
          state_d = ST_RUN;
        end else if (!busy) begin
          state_d = ST_APPLY;
        end
      end
      ST_APPLY: begin
        bus.cfg_ready = 1'b1;
        state_d       = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

endmodule

// File: tb/tb_const_gate_pipe.sv
// Directed bench for const_gate_pipe: a 4-channel/2-deep instance and a 1-channel/1-deep
// instance, each checked against a scoreboard of bench-computed results.
module tb_const_gate_pipe;

  typedef struct {
    logic [3:0] y;
    int         cyc;
    bit         lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  const_gate_pipe_if #(.WIDTH(4)) bus1 ();
  const_gate_pipe_if #(.WIDTH(1)) bus2 ();

  const_gate_pipe #(.WIDTH(4), .DEPTH(2), .X_FILL(1'b0), .RESET_MODE(8'h00)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  const_gate_pipe #(.WIDTH(1), .DEPTH(1), .X_FILL(1'b0), .RESET_MODE(2'b01)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  exp_t       sb1[$];
  exp_t       sb2[$];
  int         compared = 0;
  int         mismatched = 0;
  int         cyc = 0;
  int         pulses1 = 0;
  int         pulses2 = 0;
  logic [7:0] mode1;
  logic [1:0] mode2;
  bit         lat_on;
  bit         acc1, acc2, rdy1, rdy2, cfr1;
  logic [3:0] y1;
  logic [3:0] sa [6];
  logic [3:0] sb [6];

  // Reference behaviour of one beat for a given channel count and mode word.
  function automatic logic [3:0] model_y(input logic [3:0] a, input logic [3:0] b,
                                         input logic [7:0] m, input int w);
    logic [3:0] y;
    y = 4'b0000;
    for (int i = 0; i < w; i++) begin
      case (m[2*i +: 2])
        2'b00:   y[i] = a[i] & b[i];
        2'b01:   y[i] = 1'b0;
        2'b10:   y[i] = a[i];
        default: y[i] = 1'b0;
      endcase
    end
    return y;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic [3:0] a, input logic [3:0] b);
    bus1.in_valid = v;
    bus1.in_a     = a;
    bus1.in_b     = b;
  endtask

  // One clock: sample handshakes before the rising edge, update scoreboards, then
  // return at the following falling edge where the caller drives new inputs.
  task automatic cycle();
    exp_t e;
    #2;
    rdy1 = bus1.in_ready;
    acc1 = bus1.in_valid && bus1.in_ready;
    cfr1 = bus1.cfg_ready;
    y1   = bus1.out_y;
    rdy2 = bus2.in_ready;
    acc2 = bus2.in_valid && bus2.in_ready;
    if (acc1) sb1.push_back('{model_y(bus1.in_a, bus1.in_b, mode1, 4), cyc, lat_on});
    if (acc2) sb2.push_back('{model_y({3'b000, bus2.in_a}, {3'b000, bus2.in_b}, {6'b0, mode2}, 1), cyc, lat_on});
    if (bus1.out_valid && bus1.out_ready) begin
      check_output("dut1_sb_nonempty", 32'(sb1.size() > 0), 32'd1);
      if (sb1.size() > 0) begin
        e = sb1.pop_front();
        check_output("dut1_out_y", 32'(bus1.out_y), 32'(e.y));
        if (e.lat) check_output("dut1_latency", cyc - e.cyc, 32'd2);
      end
    end
    if (bus2.out_valid && bus2.out_ready) begin
      check_output("dut2_sb_nonempty", 32'(sb2.size() > 0), 32'd1);
      if (sb2.size() > 0) begin
        e = sb2.pop_front();
        check_output("dut2_out_y", 32'(bus2.out_y), 32'(e.y[0]));
        if (e.lat) check_output("dut2_latency", cyc - e.cyc, 32'd1);
      end
    end
    if (cfr1) begin
      pulses1++;
      mode1 = bus1.cfg_mode;
    end
    if (bus2.cfg_ready) begin
      pulses2++;
      mode2 = bus2.cfg_mode;
    end
    cyc++;
    @(negedge clk);
  endtask

  // Idle until both scoreboards are empty, bounded.
  task automatic flush(input int budget);
    int n;
    n = 0;
    while ((sb1.size() > 0 || sb2.size() > 0) && n < budget) begin
      cycle();
      n++;
    end
    check_output("flush_empty", sb1.size() + sb2.size(), 32'd0);
  endtask

  // Offer a mode and wait (bounded) for its single cfg_ready pulse.
  task automatic configure(input int which, input logic [7:0] m, output int n);
    int start;
    n = 0;
    if (which == 1) begin
      start = pulses1;
      bus1.cfg_mode  = m;
      bus1.cfg_valid = 1'b1;
      while (pulses1 == start && n < 30) begin
        cycle();
        n++;
      end
      bus1.cfg_valid = 1'b0;
      check_output("cfg1_ack", pulses1 - start, 32'd1);
    end else begin
      start = pulses2;
      bus2.cfg_mode  = m[1:0];
      bus2.cfg_valid = 1'b1;
      while (pulses2 == start && n < 30) begin
        cycle();
        n++;
      end
      bus2.cfg_valid = 1'b0;
      check_output("cfg2_ack", pulses2 - start, 32'd1);
    end
  endtask

  initial begin
    int n;
    int idx;
    int start;
    int drain_cycles;
    logic [7:0] new_mode;

    apply_stimulus(1'b0, 4'b0, 4'b0);
    bus1.out_ready = 1'b1;
    bus1.cfg_valid = 1'b0;
    bus1.cfg_mode  = 8'h00;
    bus2.in_valid  = 1'b0;
    bus2.in_a      = 1'b0;
    bus2.in_b      = 1'b0;
    bus2.out_ready = 1'b1;
    bus2.cfg_valid = 1'b0;
    bus2.cfg_mode  = 2'b00;
    mode1  = 8'h00;
    mode2  = 2'b01;
    lat_on = 1'b1;

    // Test 1: reset values, then one beat with live b.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_output("reset_out_valid", 32'(bus1.out_valid), 32'd0);
    check_output("reset_out_y", 32'(bus1.out_y), 32'd0);
    check_output("reset_in_ready", 32'(bus1.in_ready), 32'd1);
    check_output("reset_cfg_ready", 32'(bus1.cfg_ready), 32'd0);
    check_output("reset_mode_q", 32'(bus1.mode_q), 32'h00);
    check_output("reset_mode_q2", 32'(bus2.mode_q), 32'h1);
    apply_stimulus(1'b1, 4'b1011, 4'b0110);
    cycle();
    check_output("t1_accept", 32'(acc1), 32'd1);
    apply_stimulus(1'b0, 4'b0, 4'b0);
    flush(10);

    // Test 2: mode change on an empty pipe, then a beat through mixed ties.
    configure(1, 8'b11_10_01_00, n);
    check_output("t2_cfg_cycles", n, 32'd3);
    check_output("t2_mode_q", 32'(bus1.mode_q), 32'hE4);
    apply_stimulus(1'b1, 4'b1111, 4'b0001);
    cycle();
    check_output("t2_accept", 32'(acc1), 32'd1);
    apply_stimulus(1'b0, 4'b0, 4'b0);
    flush(10);

    // Test 3: six-beat stream with a mode change offered alongside beat 3.
    sa = '{4'b1111, 4'b1111, 4'b0111, 4'b1111, 4'b1111, 4'b1011};
    sb = '{4'b0000, 4'b1111, 4'b1001, 4'b0000, 4'b1111, 4'b1101};
    new_mode = 8'b00_11_10_01;
    start = pulses1;
    idx = 0;
    n = 0;
    drain_cycles = 0;
    while (idx < 6 && n < 60) begin
      apply_stimulus(1'b1, sa[idx], sb[idx]);
      if (idx == 2 && pulses1 == start) begin
        bus1.cfg_mode  = new_mode;
        bus1.cfg_valid = 1'b1;
      end
      cycle();
      if (bus1.cfg_valid) begin
        if (drain_cycles > 0) check_output("t3_drain_in_ready", 32'(rdy1), 32'd0);
        drain_cycles++;
      end
      if (cfr1) bus1.cfg_valid = 1'b0;
      if (acc1) idx++;
      n++;
    end
    apply_stimulus(1'b0, 4'b0, 4'b0);
    check_output("t3_all_sent", idx, 32'd6);
    flush(20);
    check_output("t3_one_pulse", pulses1 - start, 32'd1);
    check_output("t3_mode_q", 32'(bus1.mode_q), 32'(new_mode));

    // Test 4: downstream stall with a full pipe, then release.
    lat_on = 1'b0;
    bus1.out_ready = 1'b0;
    sa = '{4'b1100, 4'b0011, 4'b1111, 4'b1010, 4'b0000, 4'b0000};
    sb = '{4'b1010, 4'b0101, 4'b0110, 4'b1001, 4'b0000, 4'b0000};
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      apply_stimulus(1'b1, sa[idx], sb[idx]);
      cycle();
      if (acc1) idx++;
      if (c >= 2) begin
        check_output("t4_stall_in_ready", 32'(rdy1), 32'd0);
        check_output("t4_stall_out_y", 32'(y1), 32'(sb1[0].y));
      end
    end
    check_output("t4_accepted", idx, 32'd2);
    bus1.out_ready = 1'b1;
    n = 0;
    while (idx < 4 && n < 20) begin
      apply_stimulus(1'b1, sa[idx], sb[idx]);
      cycle();
      if (acc1) idx++;
      n++;
    end
    apply_stimulus(1'b0, 4'b0, 4'b0);
    flush(20);
    lat_on = 1'b1;

    // Test 5: reset while draining with a pending mode.
    bus1.out_ready = 1'b0;
    apply_stimulus(1'b1, 4'b1010, 4'b1100);
    cycle();
    apply_stimulus(1'b1, 4'b0101, 4'b1111);
    cycle();
    apply_stimulus(1'b0, 4'b0, 4'b0);
    start = pulses1;
    bus1.cfg_mode  = 8'b01_01_01_01;
    bus1.cfg_valid = 1'b1;
    repeat (3) cycle();
    check_output("t5_drain_in_ready", 32'(rdy1), 32'd0);
    #2;
    rst_n = 1'b0;
    bus1.cfg_valid = 1'b0;
    #1;
    check_output("t5_rst_out_valid", 32'(bus1.out_valid), 32'd0);
    check_output("t5_rst_out_y", 32'(bus1.out_y), 32'd0);
    check_output("t5_rst_mode_q", 32'(bus1.mode_q), 32'h00);
    check_output("t5_rst_cfg_ready", 32'(bus1.cfg_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sb1.delete();
    sb2.delete();
    mode1 = 8'h00;
    mode2 = 2'b01;
    bus1.out_ready = 1'b1;
    #1;
    check_output("t5_in_ready", 32'(bus1.in_ready), 32'd1);
    repeat (4) cycle();
    check_output("t5_no_pulse", pulses1 - start, 32'd0);
    check_output("t5_mode_kept", 32'(bus1.mode_q), 32'h00);

    // Test 6: single-channel, single-stage instance in GND mode, then LIVE.
    for (int k = 0; k < 4; k++) begin
      bus2.in_valid = 1'b1;
      bus2.in_a     = 1'b1;
      bus2.in_b     = k[0];
      cycle();
      check_output("t6_full_rate", 32'(acc2), 32'd1);
    end
    bus2.in_valid = 1'b0;
    flush(10);
    configure(2, 8'h00, n);
    check_output("t6_mode_q", 32'(bus2.mode_q), 32'h0);
    for (int k = 0; k < 4; k++) begin
      bus2.in_valid = 1'b1;
      bus2.in_a     = k[1] | k[0];
      bus2.in_b     = ~k[0];
      cycle();
      check_output("t6_live_rate", 32'(acc2), 32'd1);
    end
    bus2.in_valid = 1'b0;
    flush(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
